id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register of the 64-bit RISC-V pipeline; captures registerFile read data, decoded
//  immediate and control bits at posedge clk and presents them to EX. Owns load-use hazard
//  detection: stalls PC and IF/ID and inserts a bubble. Also honours branch flush from EX.
//  Keeps free-running stall/flush event counters for performance debug.
// PARAMETERS
//  DATA_W   64  width of register data, immediate, PC
//  REG_AW   5   register address width
//  CNT_W    32  width of stall/flush event counters
// PORTS
//  clk            in   1       clock; all state updates on posedge
//  reset          in   1       asynchronous, active-low reset (0 = reset)
//  id_valid       in   1       ID holds a real instruction
//  id_pc          in   DATA_W  PC of ID instruction
//  id_rs1,id_rs2  in   REG_AW  source regs (same values driven to registerFile)
//  id_uses_rs1/2  in   1 each  instruction actually reads rs1 / rs2
//  id_rd          in   REG_AW  destination reg
//  id_rdata1/2    in   DATA_W  registerFile readdata1/readdata2
//  id_imm         in   DATA_W  sign-extended immediate
//  id_ctrl        in   8       {reg_write,mem_read,mem_write,mem_to_reg,branch,alu_src,alu_op[1:0]}
//  ex_flush       in   1       branch taken in EX; kill ID instruction
//  stall          out  1       comb.; 1 = hold PC and IF/ID this cycle
//  ex_valid       out  1       EX holds real instruction
//  ex_pc,ex_rdata1,ex_rdata2,ex_imm  out DATA_W  registered copies
//  ex_rs1,ex_rs2,ex_rd               out REG_AW  registered copies (for forwarding unit)
//  ex_ctrl        out  8       registered control bits
//  stall_cnt      out  CNT_W   cycles with stall=1
//  flush_cnt      out  CNT_W   cycles with ex_flush=1 and id_valid=1
// BEHAVIOUR
//  Reset (reset=0, async): every registered output and both counters -> 0; stall = 0 while reset=0.
//  hazard (comb) = id_valid & ex_valid & ex_ctrl[6](mem_read) & ex_rd!=0 &
//                  ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
//  stall = hazard & ~ex_flush.
//  Posedge update, priority order:
//   1 ex_flush=1 -> bubble: ex_valid=0, ex_ctrl=0; data/addr fields captured but don't-care.
//   2 stall=1    -> bubble as above; ID instruction stays in ID (upstream holds it).
//   3 else       -> capture all id_* into ex_*; ex_valid=id_valid; ex_ctrl=id_valid?id_ctrl:0.
//  Latency 1 cycle ID->EX. Bubble always has ex_ctrl=0 so no reg/mem write can leak downstream.
//  Load-use stall lasts exactly 1 cycle: next cycle EX holds the bubble (ex_valid=0), hazard drops.
//  x0 never causes a stall (ex_rd==0 excluded). Non-load producer never stalls (forwarding covers it).
//  registerFile writes on negedge, so WB data for same-cycle ID read is already in id_rdata*; no
//   WB bypass here.
//  Counters: +1 per qualifying posedge; wrap 2^CNT_W-1 -> 0; flush+hazard same cycle counts flush only.
//  Reset asserted mid-stall: state clears immediately, stall drops combinationally.
// TESTING
//  1 Reset: hold reset=0 with random id_* -> all ex_* = 0, stall=0, counters 0; release -> capture next edge.
//  2 Pass-through: id_valid=1, pc=0x100, rdata1=5, rdata2=7, imm=-4, ctrl=8'h81 -> next cycle ex_* equal, ex_valid=1.
//  3 Load-use: EX = ld x5 (ctrl mem_read), ID = add x6,x5,x7 uses_rs1 -> stall=1 one cycle, ex_valid=0
//    bubble next, then add enters EX; stall_cnt=1.
//  4 No false stall: EX ld x0 vs ID rs1=x0; EX ld x5 vs ID rs2=x5 with uses_rs2=0; EX add x5 -> stall=0 all.
//  5 Flush+hazard same cycle: load-use condition and ex_flush=1 -> stall=0, bubble, flush_cnt+1, stall_cnt unchanged.
//  6 Counter wrap: CNT_W=4, 16 load-use stalls -> stall_cnt returns to 0; async reset mid-stall clears outputs
//    before next edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush
// handling and free-running stall/flush event counters.
module id_ex_stage #(
    parameter int DATA_W = 64,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [7:0]        id_ctrl,
    input  logic              ex_flush,
    output logic              stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_rdata1,
    output logic [DATA_W-1:0] ex_rdata2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic [7:0]        ex_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] pc_q, rdata1_q, rdata2_q, imm_q;
    logic [REG_AW-1:0] rs1_q, rs2_q, rd_q;
    logic [7:0]        ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              hazard, bubble, flush_ev;

    // Only a load in EX can't be forwarded in time; x0 is never a real dependency.
    always_comb begin
        hazard = id_valid & valid_q & ctrl_q[6] & (rd_q != '0)
               & ((id_uses_rs1 & (id_rs1 == rd_q))
                | (id_uses_rs2 & (id_rs2 == rd_q)));
        stall    = hazard & ~ex_flush & reset;
        bubble   = ex_flush | stall;
        flush_ev = ex_flush & id_valid;
        valid_d  = id_valid & ~bubble;
        ctrl_d   = valid_d ? id_ctrl : 8'h00;
        stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, stall};
        flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, flush_ev};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rdata1_q    <= '0;
            rdata2_q    <= '0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            ctrl_q      <= 8'h00;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= id_pc;
            rdata1_q    <= id_rdata1;
            rdata2_q    <= id_rdata2;
            imm_q       <= id_imm;
            rs1_q       <= id_rs1;
            rs2_q       <= id_rs2;
            rd_q        <= id_rd;
            ctrl_q      <= ctrl_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_valid  = valid_q;
    assign ex_pc     = pc_q;
    assign ex_rdata1 = rdata1_q;
    assign ex_rdata2 = rdata2_q;
    assign ex_imm    = imm_q;
    assign ex_rs1    = rs1_q;
    assign ex_rs2    = rs2_q;
    assign ex_rd     = rd_q;
    assign ex_ctrl   = ctrl_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus random traffic
// checked against a behavioural model of the EX slot.
module tb_id_ex_stage;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid, id_uses_rs1, id_uses_rs2, ex_flush;
    logic [DW-1:0] id_pc, id_rdata1, id_rdata2, id_imm;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic [7:0]    id_ctrl;
    logic          stall, ex_valid;
    logic [DW-1:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm;
    logic [AW-1:0] ex_rs1, ex_rs2, ex_rd;
    logic [7:0]    ex_ctrl;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    // Model of what sits in EX, kept as plain variables
    bit        m_valid;
    bit [63:0] m_pc, m_r1, m_r2, m_imm;
    int        m_rs1, m_rs2, m_rd;
    bit [7:0]  m_ctrl;
    int        m_stalls, m_flushes;

    id_ex_stage #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
        .id_uses_rs2(id_uses_rs2), .id_rd(id_rd), .id_rdata1(id_rdata1),
        .id_rdata2(id_rdata2), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .ex_flush(ex_flush), .stall(stall), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_ctrl(ex_ctrl), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input bit [63:0] pc,
                         input int rs1, input int rs2,
                         input bit u1, input bit u2, input int rd,
                         input bit [63:0] r1, input bit [63:0] r2,
                         input bit [63:0] imm, input bit [7:0] ctrl,
                         input bit fl);
        id_valid = v; id_pc = pc;
        id_rs1 = AW'(rs1); id_rs2 = AW'(rs2);
        id_uses_rs1 = u1; id_uses_rs2 = u2; id_rd = AW'(rd);
        id_rdata1 = r1; id_rdata2 = r2; id_imm = imm;
        id_ctrl = ctrl; ex_flush = fl;
    endtask

    task automatic model_reset();
        m_valid = 0; m_pc = 0; m_r1 = 0; m_r2 = 0; m_imm = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ctrl = 0;
        m_stalls = 0; m_flushes = 0;
    endtask

    // A load in EX whose destination (non-x0) the ID instruction reads
    function automatic bit model_load_use();
        bool_dep: begin end
        return id_valid && m_valid && m_ctrl[6] && m_rd != 0 &&
               ((id_uses_rs1 && int'(id_rs1) == m_rd) ||
                (id_uses_rs2 && int'(id_rs2) == m_rd));
    endfunction

    task automatic check_ex();
        chk("ex_valid", ex_valid, m_valid);
        chk("ex_ctrl", ex_ctrl, m_ctrl);
        chk("stall_cnt", stall_cnt, 64'(m_stalls % 16));
        chk("flush_cnt", flush_cnt, 64'(m_flushes % 16));
        if (m_valid) begin
            chk("ex_pc", ex_pc, m_pc);
            chk("ex_rdata1", ex_rdata1, m_r1);
            chk("ex_rdata2", ex_rdata2, m_r2);
            chk("ex_imm", ex_imm, m_imm);
            chk("ex_rs1", ex_rs1, 64'(m_rs1));
            chk("ex_rs2", ex_rs2, 64'(m_rs2));
            chk("ex_rd", ex_rd, 64'(m_rd));
        end
    endtask

    // One cycle: check stall mid-cycle, clock, advance model, check EX
    task automatic step();
        bit exp_stall;
        bit kill;
        exp_stall = model_load_use() && !ex_flush;
        @(negedge clk);
        chk("stall", stall, exp_stall);
        @(posedge clk);
        kill = ex_flush || exp_stall;
        if (exp_stall) m_stalls++;
        if (ex_flush && id_valid) m_flushes++;
        m_valid = id_valid && !kill;
        m_ctrl  = m_valid ? id_ctrl : 8'h00;
        m_pc = id_pc; m_r1 = id_rdata1; m_r2 = id_rdata2; m_imm = id_imm;
        m_rs1 = int'(id_rs1); m_rs2 = int'(id_rs2); m_rd = int'(id_rd);
        #1;
        check_ex();
    endtask

    initial begin
        int s0;
        model_reset();
        reset = 1'b0;
        drive(1, {$urandom, $urandom}, 5, 5, 1, 1, 5,
              {$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom}, 8'hD0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst stall", stall, 0);
        chk("rst valid", ex_valid, 0);
        chk("rst pc", ex_pc, 0);
        chk("rst rdata1", ex_rdata1, 0);
        chk("rst imm", ex_imm, 0);
        chk("rst rd", ex_rd, 0);
        chk("rst ctrl", ex_ctrl, 0);
        chk("rst scnt", stall_cnt, 0);
        chk("rst fcnt", flush_cnt, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Pass-through
        drive(1, 64'h100, 1, 2, 1, 1, 3, 64'd5, 64'd7, -64'sd4, 8'h81, 0);
        step();
        chk("pt valid", ex_valid, 1);
        chk("pt imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFFC);

        // Load-use: ld x5 then add x6,x5,x7
        drive(1, 64'h104, 1, 0, 1, 0, 5, 0, 0, 0, 8'hD2, 0);
        step();
        drive(1, 64'h108, 5, 7, 1, 1, 6, 11, 22, 0, 8'h82, 0);
        step();
        chk("lu bubble", ex_valid, 0);
        chk("lu scnt", stall_cnt, 1);
        step();
        chk("lu add in", ex_pc, 64'h108);
        chk("lu no stall", stall, 0);

        // No false stalls: ld x0 / unused rs2 / non-load producer
        drive(1, 64'h200, 1, 0, 1, 0, 0, 0, 0, 0, 8'hD2, 0);
        step();
        drive(1, 64'h204, 0, 0, 1, 1, 8, 0, 0, 0, 8'h80, 0);
        step();
        drive(1, 64'h208, 1, 0, 1, 0, 5, 0, 0, 0, 8'hD2, 0);
        step();
        drive(1, 64'h20C, 9, 5, 1, 0, 8, 0, 0, 0, 8'h80, 0);
        step();
        drive(1, 64'h210, 1, 2, 1, 1, 5, 0, 0, 0, 8'h82, 0);
        step();
        drive(1, 64'h214, 5, 5, 1, 1, 8, 0, 0, 0, 8'h80, 0);
        step();
        chk("nfs scnt", stall_cnt, 1);

        // Flush coinciding with a load-use
        drive(1, 64'h300, 1, 0, 1, 0, 5, 0, 0, 0, 8'hD2, 0);
        step();
        drive(1, 64'h304, 5, 0, 1, 0, 6, 0, 0, 0, 8'h82, 1);
        step();
        chk("fh bubble", ex_valid, 0);
        chk("fh fcnt", flush_cnt, 1);
        chk("fh scnt", stall_cnt, 1);

        // Counter wrap over 16 stalls
        s0 = m_stalls;
        for (int i = 0; i < 16; i++) begin
            drive(1, 64'(i), 1, 0, 1, 0, 3, 0, 0, 0, 8'hD2, 0);
            step();
            drive(1, 64'(i + 1000), 3, 0, 1, 0, 4, 0, 0, 0, 8'h82, 0);
            step();
            step();
        end
        chk("wrap scnt", stall_cnt, 64'(s0 % 16));
        chk("wrap n", 64'(m_stalls - s0), 16);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bit [7:0] c;
            c = 8'($urandom);
            if ($urandom_range(0, 1) == 1) c[6] = 1'b1;
            drive($urandom_range(0, 4) != 0, {$urandom, $urandom},
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom), 1'($urandom), $urandom_range(0, 3),
                  {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, c, $urandom_range(0, 7) == 0);
            step();
        end

        // Async reset while a stall is pending
        drive(1, 64'h400, 1, 0, 1, 0, 7, 0, 0, 0, 8'hD2, 0);
        step();
        drive(1, 64'h404, 7, 0, 1, 0, 8, 0, 0, 0, 8'h82, 0);
        @(negedge clk);
        chk("mr stall pre", stall, 1);
        #1 reset = 1'b0;
        #1;
        chk("mr stall", stall, 0);
        chk("mr valid", ex_valid, 0);
        chk("mr ctrl", ex_ctrl, 0);
        chk("mr rd", ex_rd, 0);
        chk("mr scnt", stall_cnt, 0);
        chk("mr fcnt", flush_cnt, 0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        step();
        chk("mr recap", ex_pc, 64'h404);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
